aes_kat_bist: RTL and testbench
===============================

Name: aes_kat_bist

Overview:
- Sequential built-in self-test controller for the iterative AES encryption engine.
- Issues FIPS-197 Appendix C known-answer vectors (AES-128/192/256) over a valid/ready request and valid response interface.
- Compares each returned ciphertext against the stored expected value and accumulates per-vector pass/fail, timeout and run statistics.
- Sits between the top-level test enable and the AES engine; replaces the single-key combinational comparator with multi-mode, handshaked, repeatable testing.

Parameters:
VEC_EN, 3'b111, enable mask; bit0 = AES-128 vector, bit1 = AES-192, bit2 = AES-256; disabled vectors are skipped.
TIMEOUT, 1024, max cycles in WAIT before a vector is declared timed out (>=2).
CNT_W, 8, width of run and pass counters.

Ports:
clk_i  in  1  clock
reset_i  in  1  synchronous active-high reset
start_i  in  1  pulse/level; starts one test run when sampled high in IDLE or DONE
req_v_o  out  1  request valid to AES engine
req_ready_i  in  1  engine accepts request
key_o  out  256  key, left-aligned (AES-128 uses [255:128], AES-192 uses [255:64]); unused bits 0
key_len_o  out  2  0=128, 1=192, 2=256
pt_o  out  128  plaintext
resp_v_i  in  1  engine response valid (single cycle)
ct_i  in  128  ciphertext
busy_o  out  1  run in progress
done_o  out  1  run finished, held until next start or reset
pass_o  out  1  done_o and all enabled vectors passed
fail_mask_o  out  3  per-vector failure (mismatch or timeout) of last run
timeout_o  out  1  any vector of last run timed out
run_count_o  out  CNT_W  completed runs, saturating
pass_count_o  out  CNT_W  passing runs, saturating

Behaviour:
- Vector ROM (constants):
  - Plaintext for all vectors: 00112233445566778899aabbccddeeff.
  - Keys: 000102..0f (128), 000102..17 (192), 000102..1f (256).
  - Expected ciphertexts: 69c4e0d86a7b0430d8cdb78070b4c55a, dda97ca4864cdfe06eaf70a0ec0d7191, 8ea2b7ca516745bfeafc49904b496089.
- Reset values: all outputs 0; state IDLE; vector index 0.
- FSM states: IDLE, SEL, ISSUE, WAIT, CHECK, DONE.
- IDLE/DONE --start_i--> SEL:
  - Clears fail_mask_o, timeout_o, done_o, pass_o.
  - Sets busy_o.
  - Index = 0.
- SEL (1 cycle):
  - If VEC_EN[idx] is set, go to ISSUE; otherwise idx++.
  - When idx passes 2, go to DONE.
  - VEC_EN = 0: the run completes with pass_o = 1 (vacuous).
- ISSUE:
  - req_v_o = 1 with key_o, key_len_o, pt_o stable until the handshake (req_v_o & req_ready_i).
  - Handshake cycle: req_v_o drops next cycle, go to WAIT, timeout counter cleared.
  - No timeout in ISSUE.
- WAIT:
  - Counter increments each cycle.
  - On resp_v_i: capture ct_i, go to CHECK.
  - If the counter reaches TIMEOUT-1 without resp_v_i: set fail_mask_o[idx] and timeout_o, go to SEL with idx++.
  - resp_v_i on the same cycle as the timeout: the response wins.
- CHECK (1 cycle): mismatch sets fail_mask_o[idx]; idx++; go to SEL.
- DONE entry:
  - busy_o = 0, done_o = 1.
  - pass_o = (fail_mask_o == 0).
  - run_count_o increments; pass_count_o increments if passing; both saturate at all-ones.
- Spurious input handling:
  - resp_v_i outside WAIT is ignored.
  - start_i while busy_o is ignored.
- Latency: SEL→ISSUE→handshake→response→CHECK; each vector takes 3 + engine latency cycles when req_ready_i is high.
- reset_i mid-run: aborts immediately, returns to reset values (counters included); req_v_o low next cycle.

Test Plan:
1. Ideal engine model (ready = 1, 11/13/15-cycle latency, correct ciphertexts), start_i pulse → 3 requests in order key_len 0,1,2; done_o = 1, pass_o = 1, fail_mask_o = 000, run_count_o = 1, pass_count_o = 1.
2. Model corrupts the AES-192 ciphertext (flip bit 0) → fail_mask_o = 010, pass_o = 0, timeout_o = 0, pass_count_o unchanged.
3. TIMEOUT = 16, model never responds to the AES-256 vector → that vector times out after 16 WAIT cycles; fail_mask_o = 100, timeout_o = 1, done_o = 1.
4. req_ready_i held low 5 cycles → req_v_o, key_o, pt_o stable all 5 cycles; exactly one request accepted per vector.
5. VEC_EN = 3'b100 → only the key_len 2 request is issued; pass_o = 1. With VEC_EN = 0 → done_o = 1 three cycles after start, no request issued.
6. reset_i asserted while in WAIT of vector 1 → next cycle all outputs 0; new start runs a full passing sequence. Additionally, with CNT_W = 2, run 5 passes → run_count_o saturates at 3.

Source files
------------

// File: rtl/aes_kat_bist.sv
// aes_kat_bist: known-answer self-test sequencer for the iterative AES
// engine; issues FIPS-197 vectors and scores the returned ciphertexts.
module aes_kat_bist #(
  parameter logic [2:0] VEC_EN  = 3'b111,
  parameter int         TIMEOUT = 1024,
  parameter int         CNT_W   = 8
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             start_i,
  output logic             req_v_o,
  input  logic             req_ready_i,
  output logic [255:0]     key_o,
  output logic [1:0]       key_len_o,
  output logic [127:0]     pt_o,
  input  logic             resp_v_i,
  input  logic [127:0]     ct_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             pass_o,
  output logic [2:0]       fail_mask_o,
  output logic             timeout_o,
  output logic [CNT_W-1:0] run_count_o,
  output logic [CNT_W-1:0] pass_count_o
);
  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] T_LAST = TW'(TIMEOUT - 1);

  localparam logic [127:0] PT =
    128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] K128 =
    128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] K192 =
    192'h000102030405060708090a0b0c0d0e0f1011121314151617;
  localparam logic [255:0] K256 =
    256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
  localparam logic [127:0] C128 =
    128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C192 =
    128'hdda97ca4864cdfe06eaf70a0ec0d7191;
  localparam logic [127:0] C256 =
    128'h8ea2b7ca516745bfeafc49904b496089;

  typedef enum logic [2:0] {
    IDLE, SEL, ISSUE, WAIT, CHECK, DONE
  } state_t;

  state_t        state, state_n;
  logic [1:0]    idx, idx_n;
  logic [TW-1:0] tcnt;
  logic [127:0]  ct_q;
  logic [127:0]  exp_ct;
  logic [255:0]  key;

  always_comb begin
    key    = '0;
    exp_ct = '0;
    unique case (1'b1)
      idx == 2'd0: begin
        key    = {K128, 128'h0};
        exp_ct = C128;
      end
      idx == 2'd1: begin
        key    = {K192, 64'h0};
        exp_ct = C192;
      end
      idx == 2'd2: begin
        key    = K256;
        exp_ct = C256;
      end
      default: ;
    endcase
  end

  // idx 3 means every vector has been visited
  always_comb begin
    state_n = state;
    idx_n   = idx;
    unique case (state)
      IDLE, DONE: begin
        if (start_i) begin
          state_n = SEL;
          idx_n   = 2'd0;
        end
      end
      SEL: begin
        if (idx == 2'd3) begin
          state_n = DONE;
        end else if (VEC_EN[idx]) begin
          state_n = ISSUE;
        end else begin
          idx_n = idx + 2'd1;
          if (idx == 2'd2) state_n = DONE;
        end
      end
      ISSUE: begin
        if (req_ready_i) state_n = WAIT;
      end
      WAIT: begin
        if (resp_v_i) begin
          state_n = CHECK;
        end else if (tcnt == T_LAST) begin
          state_n = SEL;
          idx_n   = idx + 2'd1;
        end
      end
      CHECK: begin
        state_n = SEL;
        idx_n   = idx + 2'd1;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state        <= IDLE;
      idx          <= 2'd0;
      tcnt         <= '0;
      ct_q         <= '0;
      pass_o       <= 1'b0;
      fail_mask_o  <= 3'b000;
      timeout_o    <= 1'b0;
      run_count_o  <= '0;
      pass_count_o <= '0;
    end else begin
      state <= state_n;
      idx   <= idx_n;
      if ((state == IDLE || state == DONE) && start_i) begin
        pass_o      <= 1'b0;
        fail_mask_o <= 3'b000;
        timeout_o   <= 1'b0;
      end
      if (state == ISSUE) tcnt <= '0;
      else if (state == WAIT) tcnt <= tcnt + 1'b1;
      if (state == WAIT && resp_v_i) ct_q <= ct_i;
      if (state == WAIT && !resp_v_i && tcnt == T_LAST) begin
        fail_mask_o[idx] <= 1'b1;
        timeout_o        <= 1'b1;
      end
      if (state == CHECK && ct_q != exp_ct) fail_mask_o[idx] <= 1'b1;
      if (state == SEL && state_n == DONE) begin
        pass_o <= (fail_mask_o == 3'b000);
        if (~&run_count_o) run_count_o <= run_count_o + 1'b1;
        if (fail_mask_o == 3'b000 && ~&pass_count_o)
          pass_count_o <= pass_count_o + 1'b1;
      end
    end
  end

  assign req_v_o   = (state == ISSUE);
  assign key_o     = req_v_o ? key : '0;
  assign key_len_o = req_v_o ? idx : 2'd0;
  assign pt_o      = req_v_o ? PT : '0;
  assign busy_o    = state inside {SEL, ISSUE, WAIT, CHECK};
  assign done_o    = (state == DONE);

endmodule

// File: tb/tb_aes_kat_bist.sv
// Bench for aes_kat_bist: three enable-mask instances driven by a
// randomized AES engine model and scored against a run-level model.
module tb_aes_kat_bist;
  localparam int TMO = 16;
  localparam logic [127:0] PT =
    128'h00112233445566778899aabbccddeeff;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [2:0]          rst, start, req_v, ready, resp_v;
  logic [2:0]          busy, done, pass, tmo;
  logic [2:0][255:0]   key;
  logic [2:0][1:0]     klen;
  logic [2:0][127:0]   pt, ct;
  logic [2:0][2:0]     fm;
  logic [2:0][1:0]     rc, pc;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam logic [2:0] E =
      g == 0 ? 3'b111 : g == 1 ? 3'b100 : 3'b000;
    aes_kat_bist #(.VEC_EN(E), .TIMEOUT(TMO), .CNT_W(2)) dut (
      .clk_i(clk), .reset_i(rst[g]), .start_i(start[g]),
      .req_v_o(req_v[g]), .req_ready_i(ready[g]),
      .key_o(key[g]), .key_len_o(klen[g]), .pt_o(pt[g]),
      .resp_v_i(resp_v[g]), .ct_i(ct[g]),
      .busy_o(busy[g]), .done_o(done[g]), .pass_o(pass[g]),
      .fail_mask_o(fm[g]), .timeout_o(tmo[g]),
      .run_count_o(rc[g]), .pass_count_o(pc[g]));
  end

  function automatic logic [2:0] en(input int g);
    return g == 0 ? 3'b111 : g == 1 ? 3'b100 : 3'b000;
  endfunction

  // key is the leading 128/192/256 bits of the byte ramp 00..1f
  function automatic logic [255:0] ref_key(input int l);
    logic [255:0] k =
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
    logic [255:0] m = '1;
    m = m << (64 * (2 - l));
    return k & m;
  endfunction

  function automatic logic [127:0] ref_ct(input int l);
    case (l)
      0: return 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
      1: return 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
      default: return 128'h8ea2b7ca516745bfeafc49904b496089;
    endcase
  endfunction

  function automatic int sig(input int q[$]);
    int s = 1;
    foreach (q[i]) s = s * 4 + q[i];
    return s;
  endfunction

  int         hold [3];
  logic [2:0] drop [3];
  logic [2:0] corr [3];
  int         latc [3][3];

  int           stall [3];
  int           lat [3];
  bit           pend [3];
  logic [127:0] rct [3];
  logic [255:0] snap_k [3];
  logic [127:0] snap_p [3];
  logic [1:0]   snap_l [3];
  int           unstable [3];
  int           badval [3];
  int           log_q [3][$];

  initial begin : engine
    for (int g = 0; g < 3; g++) begin
      ready[g] = 1'b1; resp_v[g] = 1'b0; ct[g] = '0;
      pend[g] = 1'b0; stall[g] = 0;
    end
    forever begin
      @(posedge clk);
      #2;
      for (int g = 0; g < 3; g++) begin
        resp_v[g] = 1'b0;
        if (rst[g]) begin
          pend[g] = 1'b0; stall[g] = 0; ready[g] = 1'b1;
          continue;
        end
        if (pend[g]) begin
          lat[g]--;
          if (lat[g] == 0) begin
            resp_v[g] = 1'b1; ct[g] = rct[g]; pend[g] = 1'b0;
          end
        end
        if (req_v[g]) begin
          if (stall[g] == 0) begin
            snap_k[g] = key[g]; snap_p[g] = pt[g]; snap_l[g] = klen[g];
          end else if (key[g] !== snap_k[g] || pt[g] !== snap_p[g]
                       || klen[g] !== snap_l[g]) begin
            unstable[g]++;
          end
          if (stall[g] < hold[g]) begin
            ready[g] = 1'b0; stall[g]++;
          end else begin
            ready[g] = 1'b1; stall[g] = 0;
            log_q[g].push_back(int'(klen[g]));
            if (key[g] !== ref_key(int'(klen[g])) || pt[g] !== PT)
              badval[g]++;
            if (!drop[g][klen[g]]) begin
              pend[g] = 1'b1;
              lat[g]  = latc[g][klen[g]];
              rct[g]  = ref_ct(int'(klen[g])) ^ 128'(corr[g][klen[g]]);
            end
          end
        end else begin
          ready[g] = 1'b1;
        end
      end
    end
  end

  int errors = 0;
  int checks = 0;
  int runs [3];
  int passes [3];
  int cyc, exp_cyc, exp_rc, exp_pc;
  logic [2:0] exp_fm;
  logic exp_to, exp_pass;
  int exp_seq[$];

  // plays one run and derives what the run should report
  task automatic run(input int g, input int poke);
    logic [2:0] e = en(g);
    log_q[g].delete(); unstable[g] = 0; badval[g] = 0;
    exp_seq.delete(); exp_fm = '0; exp_to = 1'b0; exp_cyc = 0;
    for (int i = 0; i < 3; i++) begin
      if (e[i]) begin
        exp_seq.push_back(i);
        if (drop[g][i]) begin
          exp_fm[i] = 1'b1; exp_to = 1'b1;
          exp_cyc += 2 + hold[g] + TMO;
        end else begin
          exp_fm[i] = corr[g][i];
          exp_cyc += 3 + hold[g] + latc[g][i];
        end
      end else begin
        exp_cyc += 1;
      end
    end
    if (e[2]) exp_cyc += 1;
    exp_pass = (exp_fm == 3'b000);
    runs[g]++;
    if (exp_pass) passes[g]++;
    exp_rc = runs[g] > 3 ? 3 : runs[g];
    exp_pc = passes[g] > 3 ? 3 : passes[g];
    start[g] = 1'b1;
    @(posedge clk); #1;
    start[g] = 1'b0;
    cyc = 0;
    while (!done[g] && cyc < 2000) begin
      @(posedge clk); #1;
      cyc++;
      start[g] = (cyc == poke);
    end
    start[g] = 1'b0;
  endtask

  task automatic set_cfg(input int g, input int h, input logic [2:0] d,
                         input logic [2:0] c, input int l0, input int l1,
                         input int l2);
    hold[g] = h; drop[g] = d; corr[g] = c;
    latc[g][0] = l0; latc[g][1] = l1; latc[g][2] = l2;
  endtask

  task automatic test_reset();
    rst = '1; start = '0;
    for (int g = 0; g < 3; g++) begin
      set_cfg(g, 0, 3'b000, 3'b000, 11, 13, 15);
      runs[g] = 0; passes[g] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = '0;
    for (int g = 0; g < 3; g++) begin
      checks++;
      if ({key[g], pt[g], klen[g], fm[g], rc[g], pc[g], req_v[g],
           busy[g], done[g], pass[g], tmo[g]} !== '0) begin
        errors++;
        $display("FAIL reset_outputs[%0d]: got %0h want 0", g,
                 {key[g], pt[g], klen[g], fm[g], rc[g], pc[g], req_v[g],
                  busy[g], done[g], pass[g], tmo[g]});
      end
    end
  endtask

  task automatic test_ideal();
    set_cfg(0, 0, 3'b000, 3'b000, 11, 13, 15);
    run(0, 0);
    checks++;
    if (sig(log_q[0]) !== sig(exp_seq) || badval[0] != 0) begin
      errors++;
      $display("FAIL ideal_requests: got seq %0h bad %0d want seq %0h bad 0",
               sig(log_q[0]), badval[0], sig(exp_seq));
    end
    checks++;
    if ({done[0], pass[0], fm[0], tmo[0]} !== {2'b11, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL ideal_status: got d%b p%b m%b t%b want d1 p1 m000 t0",
               done[0], pass[0], fm[0], tmo[0]);
    end
    checks++;
    if (rc[0] !== 2'(exp_rc) || pc[0] !== 2'(exp_pc) || exp_rc != 1) begin
      errors++;
      $display("FAIL ideal_counts: got %0d/%0d want 1/1", rc[0], pc[0]);
    end
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL ideal_latency: got %0d want %0d", cyc, exp_cyc);
    end
  endtask

  task automatic test_corrupt();
    set_cfg(0, 0, 3'b000, 3'b010, 11, 13, 15);
    run(0, 0);
    checks++;
    if ({fm[0], pass[0], tmo[0]} !== {exp_fm, 2'b00} || exp_fm != 3'b010) begin
      errors++;
      $display("FAIL corrupt_status: got m%b p%b t%b want m010 p0 t0",
               fm[0], pass[0], tmo[0]);
    end
    checks++;
    if (rc[0] !== 2'(exp_rc) || pc[0] !== 2'(exp_pc)) begin
      errors++;
      $display("FAIL corrupt_counts: got %0d/%0d want %0d/%0d",
               rc[0], pc[0], exp_rc, exp_pc);
    end
  endtask

  task automatic test_timeout();
    set_cfg(0, 0, 3'b100, 3'b000, 11, 13, 15);
    run(0, 0);
    checks++;
    if ({done[0], fm[0], tmo[0], pass[0]} !== {1'b1, 3'b100, 2'b10}) begin
      errors++;
      $display("FAIL timeout_status: got d%b m%b t%b p%b want d1 m100 t1 p0",
               done[0], fm[0], tmo[0], pass[0]);
    end
    checks++;
    if (cyc != exp_cyc) begin
      errors++;
      $display("FAIL timeout_latency: got %0d want %0d", cyc, exp_cyc);
    end
    // a response on the very last wait cycle still counts
    set_cfg(0, 0, 3'b000, 3'b000, TMO, 1, TMO);
    run(0, 0);
    checks++;
    if ({pass[0], fm[0], tmo[0]} !== {1'b1, 3'b000, 1'b0}) begin
      errors++;
      $display("FAIL timeout_edge: got p%b m%b t%b want p1 m000 t0",
               pass[0], fm[0], tmo[0]);
    end
  endtask

  task automatic test_stall();
    set_cfg(0, 5, 3'b000, 3'b000, 4, 7, 2);
    run(0, 0);
    checks++;
    if (unstable[0] != 0 || log_q[0].size() != 3 || badval[0] != 0) begin
      errors++;
      $display("FAIL stall_requests: got unstable %0d reqs %0d bad %0d want 0 3 0",
               unstable[0], log_q[0].size(), badval[0]);
    end
    checks++;
    if (cyc != exp_cyc || pass[0] !== 1'b1) begin
      errors++;
      $display("FAIL stall_run: got %0d cyc p%b want %0d cyc p1",
               cyc, pass[0], exp_cyc);
    end
  endtask

  task automatic test_vec_en();
    set_cfg(1, 0, 3'b000, 3'b000, 11, 13, 15);
    run(1, 0);
    checks++;
    if (sig(log_q[1]) !== sig(exp_seq) || pass[1] !== 1'b1
        || cyc != exp_cyc) begin
      errors++;
      $display("FAIL vec_en_100: got seq %0h p%b cyc %0d want seq %0h p1 cyc %0d",
               sig(log_q[1]), pass[1], cyc, sig(exp_seq), exp_cyc);
    end
    set_cfg(2, 0, 3'b000, 3'b000, 11, 13, 15);
    run(2, 0);
    checks++;
    if (log_q[2].size() != 0 || {done[2], pass[2]} !== 2'b11
        || cyc != 3) begin
      errors++;
      $display("FAIL vec_en_000: got reqs %0d d%b p%b cyc %0d want 0 d1 p1 cyc 3",
               log_q[2].size(), done[2], pass[2], cyc);
    end
  endtask

  task automatic test_busy_start();
    set_cfg(0, 1, 3'b000, 3'b000, 3, 5, 4);
    run(0, 6);
    checks++;
    if (cyc != exp_cyc || rc[0] !== 2'(exp_rc) || log_q[0].size() != 3) begin
      errors++;
      $display("FAIL busy_start: got cyc %0d runs %0d reqs %0d want %0d %0d 3",
               cyc, rc[0], log_q[0].size(), exp_cyc, exp_rc);
    end
  endtask

  task automatic test_abort();
    int n = 0;
    set_cfg(0, 0, 3'b000, 3'b000, 11, 13, 15);
    log_q[0].delete();
    start[0] = 1'b1;
    @(posedge clk); #1;
    start[0] = 1'b0;
    while (!(log_q[0].size() == 2 && !req_v[0] && busy[0]) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 500) begin
      errors++;
      $display("FAIL abort_reach_wait: got %0d cycles want < 500", n);
    end
    rst[0] = 1'b1;
    @(posedge clk); #1;
    rst[0] = 1'b0;
    runs[0] = 0; passes[0] = 0;
    checks++;
    if ({key[0], pt[0], klen[0], fm[0], rc[0], pc[0], req_v[0],
         busy[0], done[0], pass[0], tmo[0]} !== '0) begin
      errors++;
      $display("FAIL abort_outputs: got %0h want 0",
               {key[0], pt[0], klen[0], fm[0], rc[0], pc[0], req_v[0],
                busy[0], done[0], pass[0], tmo[0]});
    end
    run(0, 0);
    checks++;
    if ({pass[0], rc[0], pc[0]} !== {1'b1, 2'd1, 2'd1}) begin
      errors++;
      $display("FAIL abort_rerun: got p%b %0d/%0d want p1 1/1",
               pass[0], rc[0], pc[0]);
    end
    repeat (4) run(0, 0);
    checks++;
    if (rc[0] !== 2'(exp_rc) || pc[0] !== 2'(exp_pc) || exp_rc != 3) begin
      errors++;
      $display("FAIL count_saturate: got %0d/%0d want 3/3", rc[0], pc[0]);
    end
  endtask

  task automatic test_random();
    for (int it = 0; it < 12; it++) begin
      int g = $urandom_range(0, 1);
      logic [2:0] d = 3'($urandom_range(0, 7)) & 3'($urandom_range(0, 7));
      set_cfg(g, $urandom_range(0, 3), d, 3'($urandom_range(0, 7)),
              $urandom_range(1, TMO), $urandom_range(1, TMO),
              $urandom_range(1, TMO));
      run(g, 0);
      checks++;
      if ({fm[g], tmo[g], pass[g], done[g]} !== {exp_fm, exp_to, exp_pass, 1'b1})
      begin
        errors++;
        $display("FAIL rand_status[%0d]: got m%b t%b p%b d%b want m%b t%b p%b d1",
                 it, fm[g], tmo[g], pass[g], done[g], exp_fm, exp_to, exp_pass);
      end
      checks++;
      if (cyc != exp_cyc || sig(log_q[g]) !== sig(exp_seq)
          || unstable[g] != 0 || badval[g] != 0) begin
        errors++;
        $display("FAIL rand_flow[%0d]: got cyc %0d seq %0h u%0d b%0d want cyc %0d seq %0h u0 b0",
                 it, cyc, sig(log_q[g]), unstable[g], badval[g],
                 exp_cyc, sig(exp_seq));
      end
      checks++;
      if (rc[g] !== 2'(exp_rc) || pc[g] !== 2'(exp_pc)) begin
        errors++;
        $display("FAIL rand_counts[%0d]: got %0d/%0d want %0d/%0d",
                 it, rc[g], pc[g], exp_rc, exp_pc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_ideal();
    test_corrupt();
    test_timeout();
    test_stall();
    test_vec_en();
    test_busy_start();
    test_abort();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
